// File: rtl/vga_cmd_scheduler.sv
// Assembles 3-byte SPI command frames into a shadow config committed on vblank rise,
// and queues pixel writes that drain one per cycle only while vblank is high.
module vga_cmd_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        ss,
  input  logic        vblank,
  output logic [31:0] config_out,
  output logic        mem_write,
  output logic [1:0]  mem_x,
  output logic [2:0]  mem_y,
  output logic        mem_data,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [31:0]   CFG_RST  = 32'hBBFC_0000;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [7:0] OP_CLR_ERR = 8'h00;
  localparam logic [7:0] OP_CFG_HI  = 8'h01;
  localparam logic [7:0] OP_CFG_LO  = 8'h02;
  localparam logic [7:0] OP_COMMIT  = 8'h03;
  localparam logic [7:0] OP_PIXEL   = 8'h04;

  logic [1:0]    idx;
  logic [7:0]    b0, b1;
  logic [TW-1:0] tcnt;
  logic [31:0]   shadow;
  logic          commit_pending, vblank_d;

  // Entry layout: {y[2:0], x[1:0], data}
  logic [5:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;

  logic abort_ss, byte_ok, frame_done, timeout, vb_edge;
  logic is_pix, push, pop, drop, bad_op, pending_nxt;

  always_comb begin
    abort_ss   = ss && (idx != 2'd0);
    byte_ok    = rx_valid && !abort_ss;
    frame_done = byte_ok && (idx == 2'd2);
    timeout    = !abort_ss && !rx_valid && (idx != 2'd0) && (tcnt == T_LAST);
    vb_edge    = vblank && !vblank_d;
    pop        = vblank && (count != '0);
    is_pix     = frame_done && (b0 == OP_PIXEL);
    push       = is_pix && ((count != FULL_CNT) || pop);
    drop       = is_pix && !push;
    bad_op     = frame_done && (b0 > OP_PIXEL);

    // A COMMIT decoded in the edge cycle must survive that edge's clear.
    pending_nxt = commit_pending;
    if (vb_edge) pending_nxt = 1'b0;
    if (frame_done && (b0 == OP_COMMIT)) pending_nxt = 1'b1;

    count_nxt = count;
    if (push && !pop) count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= 2'd0;
      b0   <= 8'h00;
      b1   <= 8'h00;
      tcnt <= '0;
    end else if (abort_ss || timeout) begin
      idx  <= 2'd0;
      tcnt <= '0;
    end else if (byte_ok) begin
      tcnt <= '0;
      case (idx)
        2'd0:    begin b0 <= rx_data; idx <= 2'd1; end
        2'd1:    begin b1 <= rx_data; idx <= 2'd2; end
        default: idx <= 2'd0;
      endcase
    end else if (idx != 2'd0) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow         <= CFG_RST;
      config_out     <= CFG_RST;
      commit_pending <= 1'b0;
      vblank_d       <= 1'b0;
      err            <= 1'b0;
    end else begin
      vblank_d       <= vblank;
      commit_pending <= pending_nxt;
      if (vb_edge && commit_pending) config_out <= shadow;
      if (frame_done && (b0 == OP_CFG_HI)) shadow[31:16] <= {b1, rx_data};
      if (frame_done && (b0 == OP_CFG_LO)) shadow[15:0]  <= {b1, rx_data};
      if (abort_ss || timeout || bad_op || drop) err <= 1'b1;
      else if (frame_done && (b0 == OP_CLR_ERR)) err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {b1[4:2], b1[1:0], rx_data[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_write <= 1'b0;
      mem_x     <= 2'd0;
      mem_y     <= 3'd0;
      mem_data  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      count     <= count_nxt;
      busy      <= pending_nxt || (count_nxt != '0);
      mem_write <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        mem_y    <= fifo_mem[rd_ptr][5:3];
        mem_x    <= fifo_mem[rd_ptr][2:1];
        mem_data <= fifo_mem[rd_ptr][0];
      end
    end
  end

endmodule

// File: tb/tb_vga_cmd_scheduler.sv
// Bench for vga_cmd_scheduler: directed scenarios plus a randomized run against a queue-based model.
module tb_vga_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n, rx_valid, ss, vblank;
  logic [7:0]  rx_data;
  logic [31:0] config_out;
  logic        mem_write, mem_data, busy, err;
  logic [1:0]  mem_x;
  logic [2:0]  mem_y;

  vga_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .ss(ss),
    .vblank(vblank), .config_out(config_out), .mem_write(mem_write), .mem_x(mem_x),
    .mem_y(mem_y), .mem_data(mem_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [2:0] y; logic [1:0] x; logic d; } pix_t;

  // Reference model: frame state, config registers and the pixel queue.
  logic [31:0] m_cfg, m_shadow;
  bit          m_pending, m_err, m_vbd, m_wr;
  int          m_idx, m_idle;
  logic [7:0]  m_b [3];
  pix_t        m_out;
  pix_t        m_q [$];

  task automatic model_reset();
    m_cfg = 32'hBBFC_0000; m_shadow = 32'hBBFC_0000;
    m_pending = 0; m_err = 0; m_vbd = 0; m_wr = 0;
    m_idx = 0; m_idle = 0; m_out = '0;
    m_q.delete();
  endtask

  task automatic model_decode();
    case (m_b[0])
      8'h00: m_err = 0;
      8'h01: m_shadow[31:16] = {m_b[1], m_b[2]};
      8'h02: m_shadow[15:0]  = {m_b[1], m_b[2]};
      8'h03: m_pending = 1;
      8'h04: begin
        if (m_q.size() < DEPTH) m_q.push_back(pix_t'({m_b[1][4:2], m_b[1][1:0], m_b[2][0]}));
        else m_err = 1;
      end
      default: m_err = 1;
    endcase
  endtask

  task automatic model_step();
    bit edge_seen;
    edge_seen = vblank && !m_vbd;
    m_wr = vblank && (m_q.size() > 0);
    if (m_wr) m_out = m_q.pop_front();
    if (edge_seen && m_pending) begin m_cfg = m_shadow; m_pending = 0; end
    m_vbd = vblank;
    if (ss && m_idx != 0) begin
      m_idx = 0; m_err = 1; m_idle = 0;
    end else if (rx_valid) begin
      m_b[m_idx] = rx_data; m_idle = 0;
      if (m_idx == 2) begin model_decode(); m_idx = 0; end
      else m_idx++;
    end else if (m_idx != 0) begin
      if (m_idle == TMO - 1) begin m_idx = 0; m_err = 1; m_idle = 0; end
      else m_idle++;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); repeat ($urandom_range(0, 2)) cycle();
    send_byte(b); repeat ($urandom_range(0, 2)) cycle();
    send_byte(c);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ss = 1'b0; vblank = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (config_out !== 32'hBBFC_0000) begin errors++; $display("FAIL reset_config: got %h want %h", config_out, 32'hBBFC_0000); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if ({mem_y, mem_x, mem_data} !== 6'd0) begin errors++; $display("FAIL reset_mem_xyd: got %b want 0", {mem_y, mem_x, mem_data}); end
    @(posedge clk); #1 rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_config_commit();
    send_frame(8'h01, 8'h12, 8'h34);
    send_frame(8'h02, 8'h56, 8'h78);
    send_frame(8'h03, 8'h00, 8'h00);
    cycle();
    checks++; if (config_out !== 32'hBBFC_0000) begin errors++; $display("FAIL cfg_hold: got %h want %h", config_out, 32'hBBFC_0000); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfg_busy_pending: got %b want 1", busy); end
    vblank = 1'b1; cycle();
    checks++; if (config_out !== 32'h1234_5678) begin errors++; $display("FAIL cfg_commit: got %h want %h", config_out, 32'h1234_5678); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_busy_clear: got %b want 0", busy); end
    vblank = 1'b0; cycle();
  endtask

  task automatic test_pixel_drain();
    int pulses;
    send_frame(8'h04, 8'h1D, 8'h01);
    pulses = 0;
    repeat (3) begin
      cycle();
      if (mem_write) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL pix_no_write_active: got %0d pulses want 0", pulses); end
    vblank = 1'b1;
    repeat (4) begin
      cycle();
      if (mem_write) begin
        pulses++;
        checks++; if ({mem_y, mem_x, mem_data} !== 6'b111_01_1) begin errors++; $display("FAIL pix_fields: got y=%b x=%b d=%b want y=111 x=01 d=1", mem_y, mem_x, mem_data); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL pix_pulse_count: got %0d want 1", pulses); end
    vblank = 1'b0; cycle();
  endtask

  task automatic test_overflow();
    pix_t exp_p [5];
    logic [7:0] b1, b2;
    int n, first_at, last_at;
    for (int i = 0; i < 5; i++) begin
      b1 = 8'($urandom); b2 = 8'($urandom);
      exp_p[i] = pix_t'({b1[4:2], b1[1:0], b2[0]});
      send_frame(8'h04, b1, b2);
    end
    cycle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err); end
    vblank = 1'b1; n = 0; first_at = -1; last_at = -1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (mem_write) begin
        if (first_at < 0) first_at = c;
        last_at = c;
        if (n < 5) begin
          checks++; if ({mem_y, mem_x, mem_data} !== exp_p[n]) begin errors++; $display("FAIL ovf_order[%0d]: got %b want %b", n, {mem_y, mem_x, mem_data}, exp_p[n]); end
        end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL ovf_pulses: got %0d want 4", n); end
    checks++; if (last_at - first_at != 3) begin errors++; $display("FAIL ovf_consecutive: got span %0d want 3", last_at - first_at); end
    vblank = 1'b0;
    send_frame(8'h00, 8'h00, 8'h00); cycle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b want 0", err); end
  endtask

  task automatic test_aborts();
    send_byte(8'h01);
    ss = 1'b1; cycle(); ss = 1'b0; cycle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ss_abort_err: got %b want 1", err); end
    send_frame(8'h01, 8'hAB, 8'hCD); send_frame(8'h03, 8'h00, 8'h00);
    vblank = 1'b1; cycle(); vblank = 1'b0; cycle();
    checks++; if (config_out !== 32'hABCD_5678) begin errors++; $display("FAIL ss_abort_next_frame: got %h want %h", config_out, 32'hABCD_5678); end
    send_frame(8'h00, 8'h00, 8'h00); cycle();
    send_byte(8'h01);
    repeat (TMO - 1) cycle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", err); end
    cycle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
    send_frame(8'h02, 8'h9A, 8'hBC); send_frame(8'h03, 8'h00, 8'h00);
    vblank = 1'b1; cycle(); vblank = 1'b0; cycle();
    checks++; if (config_out !== 32'hABCD_9ABC) begin errors++; $display("FAIL timeout_idx_reset: got %h want %h", config_out, 32'hABCD_9ABC); end
  endtask

  task automatic test_races();
    int pulses;
    send_frame(8'h01, 8'h11, 8'h22);
    send_byte(8'h03); send_byte(8'h00);
    rx_valid = 1'b1; rx_data = 8'h00; vblank = 1'b1; cycle(); rx_valid = 1'b0;
    checks++; if (config_out !== 32'hABCD_9ABC) begin errors++; $display("FAIL race_commit_same_edge: got %h want %h", config_out, 32'hABCD_9ABC); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL race_commit_pending: got %b want 1", busy); end
    vblank = 1'b0; cycle(); vblank = 1'b1; cycle();
    checks++; if (config_out !== 32'h1122_9ABC) begin errors++; $display("FAIL race_commit_next_edge: got %h want %h", config_out, 32'h1122_9ABC); end
    vblank = 1'b0; cycle();
    send_frame(8'h02, 8'h55, 8'h55); send_frame(8'h03, 8'h00, 8'h00);
    send_byte(8'h02); send_byte(8'h66);
    rx_valid = 1'b1; rx_data = 8'h66; vblank = 1'b1; cycle(); rx_valid = 1'b0;
    checks++; if (config_out !== 32'h1122_5555) begin errors++; $display("FAIL race_cfg_same_edge: got %h want %h", config_out, 32'h1122_5555); end
    vblank = 1'b0; send_frame(8'h03, 8'h00, 8'h00);
    vblank = 1'b1; cycle();
    checks++; if (config_out !== 32'h1122_6666) begin errors++; $display("FAIL race_cfg_later: got %h want %h", config_out, 32'h1122_6666); end
    vblank = 1'b0; cycle();
    for (int i = 0; i < 3; i++) send_frame(8'h04, 8'($urandom), 8'($urandom));
    vblank = 1'b1; cycle();
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL drain_started: got %b want 1", mem_write); end
    rst_n = 1'b0; #1;
    model_reset();
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_drain_write: got %b want 0", mem_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_drain_busy: got %b want 0", busy); end
    checks++; if (config_out !== 32'hBBFC_0000) begin errors++; $display("FAIL rst_mid_drain_cfg: got %h want %h", config_out, 32'hBBFC_0000); end
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin cycle(); if (mem_write) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_fifo_empty: got %0d pulses want 0", pulses); end
    vblank = 1'b0; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      ss = ($urandom_range(0, 39) == 0);
      rx_valid = $urandom_range(0, 1) == 1;
      if (m_idx == 0)
        rx_data = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4));
      else
        rx_data = 8'($urandom);
      cycle();
      checks++; if (config_out !== m_cfg) begin errors++; $display("FAIL rnd_config[%0d]: got %h want %h", i, config_out, m_cfg); end
      checks++; if (mem_write !== m_wr) begin errors++; $display("FAIL rnd_mem_write[%0d]: got %b want %b", i, mem_write, m_wr); end
      checks++; if ({mem_y, mem_x, mem_data} !== m_out) begin errors++; $display("FAIL rnd_mem_xyd[%0d]: got %b want %b", i, {mem_y, mem_x, mem_data}, m_out); end
      checks++; if (busy !== (m_pending || m_q.size() != 0)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, (m_pending || m_q.size() != 0)); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", i, err, m_err); end
    end
    rx_valid = 1'b0; ss = 1'b0;
  endtask

  initial begin
    test_reset();
    test_config_commit();
    test_pixel_drain();
    test_overflow();
    test_aborts();
    test_races();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
